// File: rtl/spi_reg_ctrl_if.sv
// Shared 8-bit peripheral register bus between the SPI transaction sequencer
// (master) and the register banks (slave).
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  // Strobe semantics: bus_wr and bus_rd are single-cycle, mutually exclusive
  // strobes qualified by bus_sel/bus_addr (and bus_wdata for writes) in the
  // same cycle; the slave returns bus_rdata exactly one cycle after bus_rd and
  // never stalls the master.
  logic [4:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_wr;
  logic              bus_rd;
  logic [7:0]        bus_rdata;

  modport master (
    output bus_sel, bus_addr, bus_wdata, bus_wr, bus_rd,
    input  bus_rdata
  );

  modport slave (
    input  bus_sel, bus_addr, bus_wdata, bus_wr, bus_rd,
    output bus_rdata
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Sequences SPI slave byte events into register-bus writes and prefetched
// reads with auto-incrementing addresses.
module spi_reg_ctrl #(
  parameter int          ADDR_W     = 7,
  parameter int          NUM_PERIPH = 8,
  parameter logic [7:0]  ERR_BYTE   = 8'hFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_ss_n,
  input  logic [7:0]  spi_rcv_cmd,
  input  logic [4:0]  spi_periph_slct,
  input  logic [7:0]  spi_rcv_byte,
  input  logic        spi_write_sig,
  input  logic        spi_inc_wraddr,
  output logic [7:0]  spi_send_byte,
  spi_reg_ctrl_if.master bus,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CMD = 3'd1,
    WRITE    = 3'd2,
    RD_ISSUE = 3'd3,
    RD_CAPT  = 3'd4,
    READ     = 3'd5
  } state_t;

  localparam logic [5:0]        NUM_SEL  = 6'(NUM_PERIPH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [7:0]        send_q, send_d;
  logic [4:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              sel_ok;
  logic [ADDR_W-1:0] addr_inc;

  assign sel_ok   = {1'b0, spi_periph_slct} < NUM_SEL;
  assign addr_inc = addr_q + ADDR_ONE;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      send_q  <= 8'h00;
      sel_q   <= 5'd0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // pend_q doubles as the write-side deferred increment (so a write issued the
  // cycle after its byte strobe still sees the pre-increment address) and as
  // the one-deep increment queue while a read is in flight.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    err_d   = err_q;
    pend_d  = pend_q;
    if (state_q != IDLE && spi_ss_n) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!spi_ss_n) begin
            state_d = WAIT_CMD;
            err_d   = 1'b0;
            pend_d  = 1'b0;
          end
        end
        WAIT_CMD: begin
          if (spi_write_sig) begin
            sel_d  = spi_periph_slct;
            addr_d = spi_rcv_cmd[ADDR_W-1:0];
            err_d  = !sel_ok;
            if (spi_rcv_cmd[7]) begin
              state_d = WRITE;
            end else begin
              state_d = RD_ISSUE;
              rd_d    = sel_ok;
            end
          end
        end
        WRITE: begin
          if (pend_q) addr_d = addr_inc;
          pend_d = spi_inc_wraddr;
          if (spi_write_sig) begin
            wdata_d = spi_rcv_byte;
            wr_d    = !err_q;
          end
        end
        RD_ISSUE: begin
          state_d = RD_CAPT;
          pend_d  = pend_q | spi_inc_wraddr;
        end
        RD_CAPT: begin
          send_d  = err_q ? ERR_BYTE : bus.bus_rdata;
          state_d = READ;
          pend_d  = pend_q | spi_inc_wraddr;
        end
        READ: begin
          if (pend_q || spi_inc_wraddr) begin
            addr_d  = addr_inc;
            state_d = RD_ISSUE;
            rd_d    = !err_q;
            pend_d  = pend_q & spi_inc_wraddr;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi_send_byte = send_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_rd    = rd_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Transaction sequencer between the SPI slave and the on-chip peripheral register banks (sensor timers, sweep capture, config).
- Interprets the slave's received command, peripheral select, byte strobes and address-increment strobes.
- Drives a single shared 8-bit register bus with auto-incrementing addresses.
- Prefetches read data into the slave's transmit byte so it is ready before the next SPI byte starts shifting.

Parameters:
ADDR_W, 7, register address width within a peripheral (1..7)
NUM_PERIPH, 8, number of valid peripheral selects (1..32); selects >= NUM_PERIPH are invalid
ERR_BYTE, 8'hFF, value returned on spi_send_byte for invalid-peripheral reads

Ports:
clk_clk  in  1  system clock; all inputs synchronous to it
reset_reset_n  in  1  asynchronous active-low reset
spi_ss_n  in  1  slave select from SPI slave, already synchronised to clk_clk
spi_rcv_cmd  in  8  command byte from SPI slave; [7]=1 write, 0 read; [6:0] start address
spi_periph_slct  in  5  peripheral select from SPI slave
spi_rcv_byte  in  8  received data byte
spi_write_sig  in  1  one-cycle pulse per completed received byte
spi_inc_wraddr  in  1  one-cycle pulse per address advance
spi_send_byte  out  8  byte to transmit next (to SPI slave send_byte)
bus_sel  out  5  latched peripheral select
bus_addr  out  ADDR_W  register address
bus_wdata  out  8  write data
bus_wr  out  1  one-cycle write strobe
bus_rd  out  1  one-cycle read strobe
bus_rdata  in  8  read data, valid exactly one cycle after bus_rd
busy  out  1  high while a transaction is active (state != IDLE)
err  out  1  sticky, set on invalid select; cleared at next transaction start

Behaviour:
- Reset: state=IDLE; spi_send_byte=8'h00, bus_sel=0, bus_addr=0, bus_wdata=0, bus_wr=0, bus_rd=0, busy=0, err=0.
- States: IDLE, WAIT_CMD, WRITE, RD_ISSUE, RD_CAPT, READ.
- IDLE -> WAIT_CMD: on cycle with spi_ss_n=0. err is cleared on this transition.
- WAIT_CMD, first spi_write_sig pulse:
  - Latch bus_sel=spi_periph_slct and bus_addr=spi_rcv_cmd[ADDR_W-1:0]; the address bits above ADDR_W are ignored.
  - If spi_rcv_cmd[7]=1: -> WRITE. No bus_wr for the command byte.
  - Else: -> RD_ISSUE.
- WRITE:
  - Each spi_write_sig asserts bus_wr for 1 cycle with bus_wdata=spi_rcv_byte, at the current bus_addr.
  - Each spi_inc_wraddr increments bus_addr.
  - If both pulse in the same cycle, the write uses the pre-increment address; the increment takes effect next cycle.
- RD_ISSUE: assert bus_rd for 1 cycle -> RD_CAPT.
- RD_CAPT: spi_send_byte <= bus_rdata -> READ. Prefetch latency is 2 cycles after the command strobe.
- READ:
  - spi_inc_wraddr increments bus_addr -> RD_ISSUE.
  - spi_write_sig is ignored; no writes occur in a read transaction.
- Address wrap: bus_addr increments modulo 2^ADDR_W (max -> 0).
- Invalid select (latched bus_sel >= NUM_PERIPH):
  - err=1; bus_wr and bus_rd are suppressed for the whole transaction.
  - Reads load spi_send_byte=ERR_BYTE.
  - Address still advances.
- An increment pulse arriving while in RD_ISSUE or RD_CAPT is queued (one-deep) and processed on entry to READ. A second pulse while one is already queued is dropped.
- spi_ss_n=1 in any non-IDLE state:
  - -> IDLE next cycle; pending increments are discarded.
  - A bus_wr/bus_rd pulse already asserted completes its single cycle; no new strobes are issued.
  - An RD_CAPT in progress is abandoned; spi_send_byte keeps its value.
- spi_send_byte holds its value between loads and across transactions.
- bus_wr and bus_rd are never asserted in the same cycle.
- Asynchronous reset mid-transaction forces the reset values immediately.

Test Plan:
- Write burst: ss_n low, cmd=8'h85, slct=2, then bytes A1,B2,C3, each followed by an inc pulse -> bus_wr at addr 5,6,7 with data A1,B2,C3, bus_sel=2, err=0.
- Read prefetch: cmd=8'h10, slct=1, bus model returns addr+8'h40 -> spi_send_byte=8'h50 two cycles after the cmd strobe; after an inc pulse -> bus_rd at addr 11, spi_send_byte=8'h51.
- Wrap: ADDR_W=7, write cmd=8'hFF, two data bytes, each followed by an inc -> writes at addr 127 then 0.
- Simultaneous strobes: write_sig and inc_wraddr in the same cycle at addr 3 -> bus_wr at addr 3, bus_addr=4 the next cycle.
- Invalid select: NUM_PERIPH=8, slct=9, read cmd -> no bus_rd, spi_send_byte=8'hFF, err=1; next transaction with a valid select -> err=0.
- Abort: ss_n raised in RD_CAPT -> IDLE next cycle, busy=0, spi_send_byte unchanged; async reset mid-WRITE -> all outputs at reset values immediately.
